serial_sub_ctrl: RTL
====================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial N-bit subtractor controller: computes diff = a - b, LSB first.
//  Reuses one 1-bit full-subtractor cell, one bit per clock, with a registered borrow.
//  Sits between a register-file/ALU front end and slow arithmetic paths; trades latency for area.
//  start/busy/done handshake; result registered and held until the next accepted start.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      single clock, all state rising-edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: diff/bout valid
//  diff   out  WIDTH  a - b mod 2^WIDTH
//  bout   out  1      final borrow; 1 iff a < b (unsigned)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, diff=0, bout=0; borrow reg, count, shift regs=0.
//  rst has priority over all other inputs, including mid-RUN: the operation is aborted and no done is issued.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> load sa<=a, sb<=b, borrow<=0, count<=0, go RUN; else stay.
//   RUN: cell inputs (sa[0], sb[0], borrow).
//        sa, sb shift right 1; cell diff bit shifts into the diff shift reg MSB; borrow<=cell bout.
//        count<=count+1; when count==WIDTH-1 go DONE.
//   DONE: done=1, busy=0. diff = shift reg (bit i = i-th serial result); bout = borrow.
//        start=1 -> reload exactly as in IDLE, go RUN (back-to-back); else go IDLE.
//  Latency: start accepted at edge k -> RUN for WIDTH cycles -> done high in cycle k+WIDTH+1.
//  Throughput: one result per WIDTH+1 cycles.
//  start during RUN: ignored, no queueing; a/b may change freely while busy.
//  diff/bout: updated only on RUN->DONE; held stable through IDLE until the next result.
//   Internal shift reg is separate from the diff output register.
//  busy=1 exactly in RUN; busy and done are never high together.
//  Counter width: $clog2(WIDTH); counting wraps only by reload, never past WIDTH-1.
//  Arithmetic: pure unsigned two's-complement wrap; no overflow flag.
// STRUCTURE
//  Shared package serial_sub_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//   - default-WIDTH constant
//  Sub-module fs_bit_cell (combinational 1-bit full subtractor):
//   - in: a, b, bin; out: diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin)
//   - instantiated once
//  Controller top: FSM, counter, operand/result shift regs, borrow flop.
// TESTING
//  1. rst 2 cycles -> busy=0, done=0, diff=8'h00, bout=0; start with rst=1 -> stays IDLE.
//  2. a=8'h05, b=8'h03, start 1 cycle -> busy for 8 cycles; done in cycle 9: diff=8'h02, bout=0.
//  3. a=8'h03, b=8'h05 -> diff=8'hFE, bout=1; a=8'h00, b=8'h01 -> diff=8'hFF, bout=1.
//  4. start pulsed mid-RUN with a=8'hAA -> ignored; result is the first operands'; single done.
//  5. rst asserted in RUN cycle 4 -> IDLE next cycle, no done, diff=0; next op 8'hFF-8'hFF -> diff=0, bout=0.
//  6. start held high through DONE -> back-to-back ops, done every 9 cycles; random sweep vs a-b model.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the default operand width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: computes a - b - bin and returns the
// difference bit together with the borrow out.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one shared full-subtractor cell
// processes one bit per clock, LSB first, with a registered borrow.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic cell_diff;
    logic cell_bout;

    fs_bit_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                sd_d     = {cell_diff, sd_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                // Counter saturates at LAST; only a reload restarts it.
                if (cnt_q == LAST) begin
                    diff_d  = {cell_diff, sd_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule
